div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 30 +++
 rtl/div_step.sv | 37 +++
 rtl/div_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared CPU header for the iterative divider.
//   - word data bus width and word type
//   - divider FSM state encodings and state bus width
//   - iteration-counter width, plus a helper that sizes it for any WIDTH
// -----------------------------------------------------------------------------
package div_unit_pkg;

   // Word data bus
   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;

   // Divider FSM
   localparam int DIV_STATE_W = 2;
   typedef enum logic [DIV_STATE_W-1:0] {
      DIV_STATE_IDLE = 2'd0,
      DIV_STATE_CALC = 2'd1,
      DIV_STATE_FIX  = 2'd2,
      DIV_STATE_DONE = 2'd3
   } div_state_t;

   // Iteration counter: log2(width)+1 bits, so it can count to width
   function automatic int div_cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

   localparam int DIV_CNT_W = div_cnt_width(WORD_W);

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division iteration (purely combinational).
// The partial remainder is shifted left, the next dividend bit enters at the
// LSB, and the divisor is subtracted only if it fits.
//
// Ports
//   rem_in   [WIDTH:0]   partial remainder from the previous iteration
//   dvd_bit              next dividend bit (MSB first)
//   divisor  [WIDTH-1:0] divisor magnitude
//   rem_out  [WIDTH:0]   partial remainder after this iteration
//   q_bit                quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
   import div_unit_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   // One bit wider than the remainder so the shift never loses information.
   logic [WIDTH+1:0] shifted;

   always_comb begin
      shifted = {rem_in, dvd_bit};
      q_bit   = (shifted >= {2'b00, divisor});
      // The remainder is always below the divisor, so after a successful
      // subtraction the result fits back into WIDTH+1 bits.
      rem_out = q_bit ? (shifted[WIDTH:0] - {1'b0, divisor}) : shifted[WIDTH:0];
   end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle signed/unsigned integer divider (restoring, 1 bit per cycle).
// FSM: IDLE -> CALC (WIDTH iterations) -> FIX (sign correction) -> DONE.
// Divide by zero skips straight from IDLE to DONE.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      request, sampled only in IDLE
//   signed_op  1 = signed, 0 = unsigned (captured with start)
//   in_0       dividend (captured with start)
//   in_1       divisor  (captured with start)
//   flush      abort current operation, return to IDLE
//   busy       high in CALC and FIX
//   done       one-cycle pulse in DONE, results valid
//   quot, rem  quotient / remainder, held until the next result
//   dz, of     divide-by-zero / signed-overflow flags, held with results
// -----------------------------------------------------------------------------
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] in_0,
   input  logic [WIDTH-1:0] in_1,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             dz,
   output logic             of
);

   localparam int               CNT_W    = div_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       state;
   logic [WIDTH:0]   rem_acc;   // partial remainder
   logic [WIDTH-1:0] dvd_sh;    // dividend magnitude; quotient bits shift in at LSB
   logic [WIDTH-1:0] dvs;       // divisor magnitude
   logic [CNT_W-1:0] cnt;       // iterations completed
   logic             neg_q;     // negate quotient in FIX
   logic             neg_r;     // negate remainder in FIX
   logic             ovf;       // signed overflow pending for this operation

   // Operand preprocessing for the capture cycle
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             ovf_in;

   always_comb begin
      // NOTE: every variable gets a default before the conditional overrides;
      // a path that leaves one unassigned would infer a latch.
      a_neg  = signed_op & in_0[WIDTH-1];
      b_neg  = signed_op & in_1[WIDTH-1];
      a_mag  = in_0;
      b_mag  = in_1;
      if (a_neg) a_mag = -in_0;
      if (b_neg) b_mag = -in_1;
      ovf_in = signed_op && (in_0 == MOST_NEG) && (in_1 == '1);
   end

   // Iteration datapath
   logic [WIDTH:0] rem_nxt;
   logic           q_bit;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_acc),
      .dvd_bit (dvd_sh[WIDTH-1]),
      .divisor (dvs),
      .rem_out (rem_nxt),
      .q_bit   (q_bit)
   );

   // FSM, datapath registers and registered outputs
   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values, regardless of statement order.
      if (reset) begin
         state   <= DIV_STATE_IDLE;
         rem_acc <= '0;
         dvd_sh  <= '0;
         dvs     <= '0;
         cnt     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         ovf     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         quot    <= '0;
         rem     <= '0;
         dz      <= 1'b0;
         of      <= 1'b0;
      end else if (flush) begin
         // Abort: results and flags keep their last completed values.
         state <= DIV_STATE_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         unique case (state)
            DIV_STATE_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (in_1 == '0) begin
                     // Divide by zero: no iterations, results straight to DONE.
                     state <= DIV_STATE_DONE;
                     done  <= 1'b1;
                     quot  <= '1;
                     rem   <= in_0;
                     dz    <= 1'b1;
                     of    <= 1'b0;
                  end else begin
                     state   <= DIV_STATE_CALC;
                     busy    <= 1'b1;
                     rem_acc <= '0;
                     dvd_sh  <= a_mag;
                     dvs     <= b_mag;
                     cnt     <= '0;
                     neg_q   <= a_neg ^ b_neg;
                     neg_r   <= a_neg;
                     ovf     <= ovf_in;
                  end
               end
            end

            DIV_STATE_CALC: begin
               rem_acc <= rem_nxt;
               dvd_sh  <= {dvd_sh[WIDTH-2:0], q_bit};
               cnt     <= cnt + 1'b1;
               if (cnt == LAST_IT) state <= DIV_STATE_FIX;
            end

            DIV_STATE_FIX: begin
               // Magnitude results become truncate-toward-zero quotient and a
               // remainder carrying the dividend's sign. For MOST_NEG / -1 the
               // magnitude quotient is MOST_NEG and the signs match, so the
               // quotient already equals the dividend and the remainder is 0.
               quot  <= neg_q ? -dvd_sh : dvd_sh;
               rem   <= neg_r ? -rem_acc[WIDTH-1:0] : rem_acc[WIDTH-1:0];
               dz    <= 1'b0;
               of    <= ovf;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DIV_STATE_DONE;
            end

            DIV_STATE_DONE: begin
               // A start seen here is dropped; it is accepted next cycle in IDLE.
               done  <= 1'b0;
               state <= DIV_STATE_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= DIV_STATE_IDLE;
            end
         endcase
      end
   end

endmodule
